// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline-stage register: upstream side
// (in_*) and downstream side (out_*) carried together.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with flush, optional 2-entry skid buffer
// (registered ready) and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] main_s;
    logic [DATA_W-1:0] skid_r;
    logic [DATA_W-1:0] skid_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              ti_s;
    logic              to_s;

    // With the skid buffer, ready depends only on the state register; without it
    // ready looks through to out_ready_i so a full stage can still stream.
    assign out_valid_s = (state_r != ST_EMPTY);
    assign in_ready_s  = (SKID != 0) ? (state_r != ST_SKID)
                                     : ((state_r == ST_EMPTY) | bus.out_ready_i);
    assign ti_s        = bus.in_valid_i & in_ready_s;
    assign to_s        = out_valid_s & bus.out_ready_i;

    // Next-state and payload steering; flush overrides every transition.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (flush_i) begin
            state_s = ST_EMPTY;
            main_s  = FLUSH_VAL;
            skid_s  = FLUSH_VAL;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (ti_s) begin
                        state_s = ST_FULL;
                        main_s  = bus.in_data_i;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (ti_s && to_s) begin
                        main_s = bus.in_data_i;
                    end else if (ti_s) begin
                        // Only reachable with the skid buffer: park the newer entry.
                        state_s = ST_SKID;
                        skid_s  = bus.in_data_i;
                    end else if (to_s) begin
                        state_s = ST_EMPTY;
                        main_s  = FLUSH_VAL;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (to_s) begin
                        state_s = ST_FULL;
                        main_s  = skid_r;
                        skid_s  = FLUSH_VAL;
                    end else begin
                        state_s = ST_SKID;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                    main_s  = FLUSH_VAL;
                    skid_s  = FLUSH_VAL;
                end
            endcase
        end
    end

    // Stall counter saturates instead of wrapping; flush does not clear it.
    always_comb begin
        if (out_valid_s && !bus.out_ready_i && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, payload and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_EMPTY;
            main_r  <= FLUSH_VAL;
            skid_r  <= FLUSH_VAL;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            main_r  <= main_s;
            skid_r  <= skid_s;
            cnt_r   <= cnt_s;
        end
    end

    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = out_valid_s;
    assign bus.out_data_o  = main_r;
    assign stall_cnt_o     = cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (64-bit skid, 8-bit skid with 4-bit
// counter, 8-bit single register) share stimulus and are checked against a FIFO model.
module tb_pipe_stage_reg;

    localparam logic [63:0] FV_A = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [7:0]  FV_B = 8'h5A;
    localparam logic [7:0]  FV_C = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] sc_a;
    logic [3:0]  sc_b;
    logic [3:0]  sc_c;

    pipe_stage_reg_if #(.DATA_W(64)) if_a ();
    pipe_stage_reg_if #(.DATA_W(8))  if_b ();
    pipe_stage_reg_if #(.DATA_W(8))  if_c ();

    pipe_stage_reg #(.DATA_W(64), .FLUSH_VAL(FV_A), .SKID(1), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_a), .stall_cnt_o(sc_a));
    pipe_stage_reg #(.DATA_W(8), .FLUSH_VAL(FV_B), .SKID(1), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_b), .stall_cnt_o(sc_b));
    pipe_stage_reg #(.DATA_W(8), .FLUSH_VAL(FV_C), .SKID(0), .CNT_W(4)) dut_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_c), .stall_cnt_o(sc_c));

    always #5 clk = ~clk;

    // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
    logic [63:0] mq     [3][2];
    int          mcnt   [3];
    int          mstall [3];
    int          cap    [3];
    int          satmax [3];
    logic [63:0] fvm    [3];
    logic [63:0] dmask  [3];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int id, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d: got %h want %h", tag, id, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
        if_a.in_valid_i = iv;  if_a.in_data_i = d;      if_a.out_ready_i = ordy;
        if_b.in_valid_i = iv;  if_b.in_data_i = d[7:0]; if_b.out_ready_i = ordy;
        if_c.in_valid_i = iv;  if_c.in_data_i = d[7:0]; if_c.out_ready_i = ordy;
        flush = fl;
    endtask

    function automatic logic exp_ready(input int id, input logic ordy);
        if (cap[id] == 2) return (mcnt[id] < 2);
        return (mcnt[id] == 0) || ordy;
    endfunction

    task automatic check_all(input logic ordy);
        logic [63:0] ov [3];
        logic [63:0] od [3];
        logic [63:0] ir [3];
        logic [63:0] sc [3];
        ov[0] = {63'd0, if_a.out_valid_o}; od[0] = if_a.out_data_o;
        ir[0] = {63'd0, if_a.in_ready_o};  sc[0] = {48'd0, sc_a};
        ov[1] = {63'd0, if_b.out_valid_o}; od[1] = {56'd0, if_b.out_data_o};
        ir[1] = {63'd0, if_b.in_ready_o};  sc[1] = {60'd0, sc_b};
        ov[2] = {63'd0, if_c.out_valid_o}; od[2] = {56'd0, if_c.out_data_o};
        ir[2] = {63'd0, if_c.in_ready_o};  sc[2] = {60'd0, sc_c};
        for (int id = 0; id < 3; id++) begin
            chk("out_valid", id, ov[id], (mcnt[id] > 0) ? 64'd1 : 64'd0);
            chk("out_data", id, od[id], (mcnt[id] > 0) ? mq[id][0] : fvm[id]);
            chk("in_ready", id, ir[id], {63'd0, exp_ready(id, ordy)});
            chk("stall_cnt", id, sc[id], 64'(mstall[id]));
        end
    endtask

    task automatic model_step(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
        for (int id = 0; id < 3; id++) begin
            logic ti;
            logic to;
            ti = iv && exp_ready(id, ordy);
            to = (mcnt[id] > 0) && ordy;
            if ((mcnt[id] > 0) && !ordy && (mstall[id] < satmax[id])) mstall[id]++;
            if (fl) begin
                mcnt[id] = 0;
            end else begin
                if (to) begin
                    mq[id][0] = mq[id][1];
                    mcnt[id]--;
                end
                if (ti) begin
                    mq[id][mcnt[id]] = d & dmask[id];
                    mcnt[id]++;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id < 3; id++) begin
            mcnt[id]   = 0;
            mstall[id] = 0;
        end
    endtask

    task automatic cycle(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        drive(iv, d, ordy, fl);
        #1;
        check_all(ordy);
        model_step(iv, d, ordy, fl);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge arrives.
    task automatic async_reset();
        @(negedge clk);
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        cap[0] = 2;  cap[1] = 2;  cap[2] = 1;
        satmax[0] = 65535; satmax[1] = 15; satmax[2] = 15;
        fvm[0] = FV_A; fvm[1] = {56'd0, FV_B}; fvm[2] = {56'd0, FV_C};
        dmask[0] = {64{1'b1}}; dmask[1] = 64'hFF; dmask[2] = 64'hFF;
        for (int id = 0; id < 3; id++) begin
            mq[id][0] = 64'd0;
            mq[id][1] = 64'd0;
        end
        rst = 1'b1;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #2;
        model_reset();
        check_all(1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream with downstream always ready.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 64'(i), 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // Backpressure into the skid entry, then drain.
        cycle(1'b1, 64'hA, 1'b1, 1'b0);
        cycle(1'b1, 64'hB, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // Flush while both entries are held, with a competing input.
        cycle(1'b1, 64'hA, 1'b1, 1'b0);
        cycle(1'b1, 64'hB, 1'b0, 1'b0);
        cycle(1'b1, 64'hC, 1'b0, 1'b1);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a stall.
        cycle(1'b1, 64'h1, 1'b1, 1'b0);
        cycle(1'b1, 64'h2, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0);
        async_reset();
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // Counter saturation on the 4-bit counters.
        cycle(1'b1, 64'h77, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 64'd0, 1'b0, 1'b0);
        cycle(1'b1, 64'h55, 1'b1, 1'b0);
        cycle(1'b1, 64'h66, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        async_reset();

        // Randomised traffic with occasional flushes and resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, {$urandom, $urandom},
                      $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline-stage register. It generalises the fixed 32-bit stall/flush stage registers between CPU pipeline stages. It carries a DATA_W-bit payload with a valid/ready handshake, a synchronous flush, and an optional 2-entry skid buffer that breaks the combinational ready path. A saturating stall-cycle counter is exposed for performance debug. It is instantiated between any two pipeline stages (IF/ID, ID/EX, ...).

Parameters:
DATA_W, 64, payload width in bits (>=1)
FLUSH_VAL, 0, value loaded into payload registers on reset and flush (DATA_W bits)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single register with combinational in_ready_o
CNT_W, 16, width of the stall-cycle counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  synchronous flush, discards all held entries
in_valid_i  in  1  upstream has a payload
in_ready_o  out  1  stage can accept this cycle
in_data_i  in  DATA_W  upstream payload
out_valid_o  out  1  main register holds a valid payload
out_ready_i  in  1  downstream accepts this cycle
out_data_o  out  DATA_W  main register payload
stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating

Behaviour:
- Transfer-in (TI) = in_valid_i & in_ready_o. Transfer-out (TO) = out_valid_o & out_ready_i.
- Reset (async, any time, including mid-transfer): state EMPTY, out_valid_o=0, main/skid data=FLUSH_VAL, stall_cnt_o=0, in_ready_o=1. Released on the first clock edge after rst_i falls.
- SKID=1 state machine (states EMPTY, FULL, SKID; in_ready_o = (state != SKID), decoded from a register, with no combinational path from out_ready_i):
  - EMPTY: TI -> FULL, main<=in_data_i.
  - FULL: TI&TO -> FULL, main<=in_data_i. TI&!TO -> SKID, skid<=in_data_i. !TI&TO -> EMPTY. Neither -> hold.
  - SKID: TO -> FULL, main<=skid. No TO -> hold. No TI is possible.
- SKID=0: one register. in_ready_o = !out_valid_o | out_ready_i. On TI, main<=in_data_i and valid=1. On TO without TI, valid=0.
- Latency: 1 cycle from TI to out_valid_o when empty. Throughput 1 per cycle under continuous out_ready_i in both modes.
- Ordering: strict FIFO. The skid entry is never emitted before the main entry.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o is held bit-exact.
- Flush, highest priority after reset:
  - Next state EMPTY, out_valid_o=0, main/skid data<=FLUSH_VAL.
  - A TI in the flush cycle is discarded.
  - A TO in the flush cycle completes normally; downstream takes out_data_o.
  - stall_cnt_o is not cleared by flush.
- Empty output: when out_valid_o=0, out_data_o=FLUSH_VAL after reset/flush or after the last TO.
- Stall counter: increments by 1 each cycle with out_valid_o & !out_ready_i, including a flush cycle. It saturates at 2^CNT_W-1 with no wrap and is cleared only by rst_i.
- Simultaneous flush with the SKID state: both entries are dropped and in_ready_o=1 on the next cycle.

Test Plan:
- Reset then stream: DATA_W=64, SKID=1, feed 0x1..0x8 back-to-back with out_ready_i=1 -> out_data_o=0x1..0x8 on consecutive cycles starting 1 cycle after the first TI; in_ready_o stays 1; stall_cnt_o=0.
- Backpressure/skid: stage holds 0xA (FULL); present 0xB with out_ready_i=0 -> 0xB accepted, state SKID, in_ready_o=0 next cycle, out_data_o holds 0xA. Raise out_ready_i -> outputs 0xA then 0xB; stall_cnt_o equals the number of stalled cycles (e.g. 3).
- Flush in SKID: entries 0xA,0xB held, flush_i=1 with in_valid_i=1, data 0xC -> next cycle out_valid_o=0, out_data_o=FLUSH_VAL, 0xC never appears, in_ready_o=1.
- Async reset mid-stall: stage in SKID, assert rst_i between edges -> out_valid_o=0 and stall_cnt_o=0 immediately, without waiting for a clock edge.
- Counter saturation: CNT_W=4, hold out_ready_i=0 with valid payload for 20 cycles -> stall_cnt_o reaches 15 and stays 15.
- SKID=0 mode: out_valid_o=1, out_ready_i=1, in_valid_i=1, data 0x55 -> in_ready_o=1 in the same cycle and 0x55 is on out_data_o next cycle. With out_ready_i=0, in_ready_o=0 in the same cycle.
